// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - CSR addresses, cause codes, op encoding and FSM state for csr_trap_unit
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS       = 12'h300;
  localparam logic [11:0] CSR_MIE           = 12'h304;
  localparam logic [11:0] CSR_MTVEC         = 12'h305;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
  localparam logic [11:0] CSR_MEPC          = 12'h341;
  localparam logic [11:0] CSR_MCAUSE        = 12'h342;
  localparam logic [11:0] CSR_MTVAL         = 12'h343;
  localparam logic [11:0] CSR_MIP           = 12'h344;
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;

  localparam logic [4:0] EXC_IADDR_MISALIGNED = 5'd0;
  localparam logic [4:0] EXC_ILLEGAL_INSN     = 5'd2;
  localparam logic [4:0] EXC_BREAKPOINT       = 5'd3;
  localparam logic [4:0] EXC_ECALL_M          = 5'd11;

  localparam logic [4:0] IRQ_MSI        = 5'd3;
  localparam logic [4:0] IRQ_MTI        = 5'd7;
  localparam logic [4:0] IRQ_MEI        = 5'd11;
  localparam logic [4:0] IRQ_LOCAL_BASE = 5'd16;

  localparam logic [1:0] CSR_OP_NONE  = 2'b00;
  localparam logic [1:0] CSR_OP_WRITE = 2'b01;
  localparam logic [1:0] CSR_OP_SET   = 2'b10;
  localparam logic [1:0] CSR_OP_CLEAR = 2'b11;

  typedef logic [0:0] state_t;
  localparam state_t ST_RUN  = 1'b0;
  localparam state_t ST_TAKE = 1'b1;

  function automatic logic [31:0] csr_apply(input logic [1:0] op, input logic [31:0] old_val,
                                            input logic [31:0] wdata);
    case (op)
      CSR_OP_SET:   return old_val | wdata;
      CSR_OP_CLEAR: return old_val & ~wdata;
      default:      return wdata;
    endcase
  endfunction

endpackage

// File: rtl/csr_trap_unit_if.sv
// rtl/csr_trap_unit_if.sv - CSR access bus between decode/execute and the CSR/trap unit
interface csr_trap_unit_if;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;

  modport master (output csr_addr, output csr_op, output csr_wdata, input csr_rdata);
  modport slave  (input csr_addr, input csr_op, input csr_wdata, output csr_rdata);
endinterface

// File: rtl/csr_counter64.sv
// rtl/csr_counter64.sv - 64-bit event counter with inhibit and per-half write ports
module csr_counter64 (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        inc_i,
  input  logic        inhibit_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] count_o
);

  logic [63:0] cnt_q, cnt_d;

  // A write to either half suppresses that cycle's increment entirely.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !inhibit_i) cnt_d = cnt_q + 64'd1;
    if (wr_lo_i)             cnt_d = {cnt_q[63:32], wdata_i};
    if (wr_hi_i)             cnt_d = {wdata_i, cnt_q[31:0]};
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/csr_trap_unit.sv
// rtl/csr_trap_unit.sv - machine-mode CSR file and trap controller
module csr_trap_unit
  import csr_pkg::*;
#(
  parameter int          NUM_LIRQ    = 4,
  parameter bit          COUNTERS_EN = 1'b1,
  parameter logic [31:0] RESET_MTVEC = 32'h0
) (
  input  logic                                       clk_i,
  input  logic                                       reset_i,
  input  logic [31:0]                                pc_i,
  csr_trap_unit_if.slave                             csr_bus,
  input  logic                                       meip_i,
  input  logic                                       mtip_i,
  input  logic                                       msip_i,
  input  logic [(NUM_LIRQ > 0 ? NUM_LIRQ : 1)-1:0]   lirq_i,
  input  logic                                       exc_valid_i,
  input  logic [3:0]                                 exc_cause_i,
  input  logic [31:0]                                exc_tval_i,
  input  logic                                       mret_i,
  input  logic                                       retire_i,
  output logic                                       trap_o,
  output logic [31:0]                                trap_pc_o,
  output logic [31:0]                                mepc_o,
  output logic                                       irq_ack_o,
  output logic [4:0]                                 irq_ack_id_o
);

  localparam logic [31:0] LIRQ_MASK = (32'h0000_FFFF >> (16 - NUM_LIRQ)) << 16;
  localparam logic [31:0] MIE_MASK  = 32'h0000_0888 | LIRQ_MASK;

  state_t      state_q, state_d;
  logic        st_mie_q, st_mie_d, st_mpie_q, st_mpie_d;
  logic [31:0] mie_q, mie_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
  logic [31:0] mip_q, mip_in;
  logic        inh_cy_q, inh_cy_d, inh_ir_q, inh_ir_d;
  logic [31:0] trap_pc_q, trap_pc_d;
  logic [4:0]  ack_id_q, ack_id_d;
  logic        take_irq_q, take_irq_d;
  logic [63:0] mcycle, minstret;
  logic [31:0] rdata, wval;
  logic        running, csr_we, take, is_irq, irq_sel, lirq_hit;
  logic [4:0]  irq_cause, lirq_cause, cause;
  logic [31:0] trap_target;

  always_comb begin
    mip_in     = '0;
    mip_in[3]  = msip_i;
    mip_in[7]  = mtip_i;
    mip_in[11] = meip_i;
    for (int i = 0; i < NUM_LIRQ; i++) mip_in[16+i] = lirq_i[i];
  end

  always_comb begin
    case (csr_bus.csr_addr)
      CSR_MSTATUS:       rdata = {19'b0, 2'b11, 3'b0, st_mpie_q, 3'b0, st_mie_q, 3'b0};
      CSR_MIE:           rdata = mie_q;
      CSR_MTVEC:         rdata = mtvec_q;
      CSR_MSCRATCH:      rdata = mscratch_q;
      CSR_MEPC:          rdata = mepc_q;
      CSR_MCAUSE:        rdata = mcause_q;
      CSR_MTVAL:         rdata = mtval_q;
      CSR_MIP:           rdata = mip_q;
      CSR_MCOUNTINHIBIT: rdata = {29'b0, inh_ir_q, 1'b0, inh_cy_q};
      CSR_MCYCLE:        rdata = mcycle[31:0];
      CSR_MCYCLEH:       rdata = mcycle[63:32];
      CSR_MINSTRET:      rdata = minstret[31:0];
      CSR_MINSTRETH:     rdata = minstret[63:32];
      default:           rdata = '0;
    endcase
  end

  assign csr_bus.csr_rdata = rdata;

  // Fixed priority MEI > MSI > MTI > local lines; the descending loop leaves the lowest index.
  always_comb begin
    lirq_hit   = 1'b0;
    lirq_cause = '0;
    for (int i = NUM_LIRQ - 1; i >= 0; i--) begin
      if (mip_q[16+i] && mie_q[16+i]) begin
        lirq_hit   = 1'b1;
        lirq_cause = IRQ_LOCAL_BASE + 5'(i);
      end
    end
    irq_sel   = 1'b1;
    irq_cause = '0;
    if      (mip_q[11] && mie_q[11]) irq_cause = IRQ_MEI;
    else if (mip_q[3]  && mie_q[3])  irq_cause = IRQ_MSI;
    else if (mip_q[7]  && mie_q[7])  irq_cause = IRQ_MTI;
    else if (lirq_hit)               irq_cause = lirq_cause;
    else                             irq_sel   = 1'b0;
  end

  assign running = (state_q == ST_RUN);
  assign take    = running && (exc_valid_i || (st_mie_q && irq_sel));
  assign is_irq  = !exc_valid_i;
  assign cause   = exc_valid_i ? {1'b0, exc_cause_i} : irq_cause;
  assign csr_we  = running && (csr_bus.csr_op != CSR_OP_NONE);
  assign wval    = csr_apply(csr_bus.csr_op, rdata, csr_bus.csr_wdata);
  assign trap_target = {mtvec_q[31:2], 2'b00} +
                       ((is_irq && mtvec_q[1:0] == 2'b01) ? {25'b0, cause, 2'b00} : 32'b0);

  always_comb begin
    state_d    = take ? ST_TAKE : ST_RUN;
    st_mie_d   = st_mie_q;
    st_mpie_d  = st_mpie_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    inh_cy_d   = inh_cy_q;
    inh_ir_d   = inh_ir_q;
    trap_pc_d  = trap_pc_q;
    ack_id_d   = ack_id_q;
    take_irq_d = take_irq_q;
    if (csr_we) begin
      case (csr_bus.csr_addr)
        CSR_MSTATUS: begin
          st_mie_d  = wval[3];
          st_mpie_d = wval[7];
        end
        CSR_MIE:      mie_d      = wval & MIE_MASK;
        CSR_MTVEC:    mtvec_d    = {wval[31:2], wval[1] ? 2'b00 : wval[1:0]};
        CSR_MSCRATCH: mscratch_d = wval;
        CSR_MEPC:     mepc_d     = {wval[31:2], 2'b00};
        CSR_MCAUSE:   mcause_d   = wval;
        CSR_MTVAL:    mtval_d    = wval;
        CSR_MCOUNTINHIBIT: begin
          inh_cy_d = COUNTERS_EN && wval[0];
          inh_ir_d = COUNTERS_EN && wval[2];
        end
        default: ;
      endcase
    end
    if (running && !exc_valid_i && mret_i) begin
      st_mie_d  = st_mpie_q;
      st_mpie_d = 1'b1;
    end
    // Trap entry overrides any same-cycle CSR write or mret to these registers.
    if (take) begin
      mepc_d     = {pc_i[31:2], 2'b00};
      mcause_d   = {is_irq, 26'b0, cause};
      mtval_d    = is_irq ? 32'b0 : exc_tval_i;
      st_mpie_d  = st_mie_q;
      st_mie_d   = 1'b0;
      trap_pc_d  = trap_target;
      ack_id_d   = is_irq ? cause : 5'd0;
      take_irq_d = is_irq;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_RUN;
      st_mie_q   <= 1'b0;
      st_mpie_q  <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= RESET_MTVEC;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mip_q      <= '0;
      inh_cy_q   <= 1'b0;
      inh_ir_q   <= 1'b0;
      trap_pc_q  <= '0;
      ack_id_q   <= '0;
      take_irq_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      st_mie_q   <= st_mie_d;
      st_mpie_q  <= st_mpie_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      mip_q      <= mip_in & MIE_MASK;
      inh_cy_q   <= inh_cy_d;
      inh_ir_q   <= inh_ir_d;
      trap_pc_q  <= trap_pc_d;
      ack_id_q   <= ack_id_d;
      take_irq_q <= take_irq_d;
    end
  end

  generate
    if (COUNTERS_EN) begin : g_counters
      csr_counter64 u_mcycle (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .inc_i     (1'b1),
        .inhibit_i (inh_cy_q),
        .wr_lo_i   (csr_we && csr_bus.csr_addr == CSR_MCYCLE),
        .wr_hi_i   (csr_we && csr_bus.csr_addr == CSR_MCYCLEH),
        .wdata_i   (wval),
        .count_o   (mcycle)
      );
      csr_counter64 u_minstret (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .inc_i     (retire_i && running),
        .inhibit_i (inh_ir_q),
        .wr_lo_i   (csr_we && csr_bus.csr_addr == CSR_MINSTRET),
        .wr_hi_i   (csr_we && csr_bus.csr_addr == CSR_MINSTRETH),
        .wdata_i   (wval),
        .count_o   (minstret)
      );
    end else begin : g_no_counters
      assign mcycle   = '0;
      assign minstret = '0;
    end
  endgenerate

  assign trap_o       = (state_q == ST_TAKE);
  assign trap_pc_o    = trap_pc_q;
  assign mepc_o       = {mepc_q[31:2], 2'b00};
  assign irq_ack_o    = trap_o && take_irq_q;
  assign irq_ack_id_o = ack_id_q;

endmodule
